// File: rtl/cache_access_arbiter.sv
// Two-requester round-robin front end sharing the cache simulator's single lookup port.
// Define ARB_STATS_EN to build the per-requester saturating hit/miss counters.
module cache_access_arbiter #(
    parameter int ADDR_W  = 31,
    parameter int CNT_W   = 31,
    parameter int TIMEOUT = 255
) (
    input  logic              clock_10,
    input  logic              reset_10,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic              resp0_hit,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic              resp1_hit,

    output logic              cache_req,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_resp_valid,
    input  logic              cache_resp_hit,

    output logic              busy,
    output logic              timeout_err,

    output logic [CNT_W-1:0]  hit_cnt0,
    output logic [CNT_W-1:0]  miss_cnt0,
    output logic [CNT_W-1:0]  hit_cnt1,
    output logic [CNT_W-1:0]  miss_cnt1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int         TMR_W    = 16;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             owner;
    logic             ptr;
    logic [TMR_W-1:0] timer;

    logic             grant_any;
    logic             grant_id;
    logic             done;
    logic             done_hit;

    // Grant only in IDLE; with both requesters pending the pointer breaks the tie.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;
    assign cache_req  = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);

    // A real response on the final timer cycle wins over the timeout.
    assign done     = (state == ST_WAIT) && (cache_resp_valid || (timer == TMR_LAST));
    assign done_hit = cache_resp_valid && cache_resp_hit;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_10 or negedge reset_10) begin
        if (!reset_10) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            ptr         <= 1'b0;
            cache_addr  <= '0;
            timer       <= '0;
            resp0_valid <= 1'b0;
            resp0_hit   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_hit   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;

            if (grant_any) begin
                owner      <= grant_id;
                ptr        <= ~grant_id;
                cache_addr <= grant_id ? req1_addr : req0_addr;
            end

            if (state == ST_ISSUE) begin
                timer <= TMR_LOAD;
            end else if ((state == ST_WAIT) && !done) begin
                timer <= timer - TMR_LAST;
            end

            resp0_valid <= done && !owner;
            resp0_hit   <= done && !owner && done_hit;
            resp1_valid <= done &&  owner;
            resp1_hit   <= done &&  owner && done_hit;

            if (done && !cache_resp_valid) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counters update on the same edge that registers the response pulse, and stick at all-ones.
    always_ff @(posedge clock_10 or negedge reset_10) begin
        if (!reset_10) begin
            hit_cnt0  <= '0;
            miss_cnt0 <= '0;
            hit_cnt1  <= '0;
            miss_cnt1 <= '0;
        end else if (done) begin
            case ({owner, done_hit})
                2'b01:   if (hit_cnt0  != '1) hit_cnt0  <= hit_cnt0  + CNT_ONE;
                2'b00:   if (miss_cnt0 != '1) miss_cnt0 <= miss_cnt0 + CNT_ONE;
                2'b11:   if (hit_cnt1  != '1) hit_cnt1  <= hit_cnt1  + CNT_ONE;
                default: if (miss_cnt1 != '1) miss_cnt1 <= miss_cnt1 + CNT_ONE;
            endcase
        end
    end
`else
    assign hit_cnt0  = '0;
    assign miss_cnt0 = '0;
    assign hit_cnt1  = '0;
    assign miss_cnt1 = '0;
`endif

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Self-checking bench for cache_access_arbiter: directed scenarios plus randomized lookups
// compared against a transaction-level model of grants, responses and statistics.
module tb_cache_access_arbiter;

    localparam int ADDR_W  = 31;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock_10 = 1'b0;
    logic              reset_10 = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic              req0_ready;
    logic              resp0_valid;
    logic              resp0_hit;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic              req1_ready;
    logic              resp1_valid;
    logic              resp1_hit;
    logic              cache_req;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_resp_valid = 1'b0;
    logic              cache_resp_hit = 1'b0;
    logic              busy;
    logic              timeout_err;
    logic [CNT_W-1:0]  hit_cnt0;
    logic [CNT_W-1:0]  miss_cnt0;
    logic [CNT_W-1:0]  hit_cnt1;
    logic [CNT_W-1:0]  miss_cnt1;

    cache_access_arbiter #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_10        (clock_10),
        .reset_10        (reset_10),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_ready      (req0_ready),
        .resp0_valid     (resp0_valid),
        .resp0_hit       (resp0_hit),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_ready      (req1_ready),
        .resp1_valid     (resp1_valid),
        .resp1_hit       (resp1_hit),
        .cache_req       (cache_req),
        .cache_addr      (cache_addr),
        .cache_resp_valid(cache_resp_valid),
        .cache_resp_hit  (cache_resp_hit),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .hit_cnt0        (hit_cnt0),
        .miss_cnt0       (miss_cnt0),
        .hit_cnt1        (hit_cnt1),
        .miss_cnt1       (miss_cnt1)
    );

    always #5 clock_10 = ~clock_10;

    // Reference model: preferred requester, per-requester hit/miss tallies, sticky timeout.
    bit m_ptr;
    int m_hit[2];
    int m_miss[2];
    bit m_terr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int v);
`ifdef ARB_STATS_EN
        return 64'(v);
`else
        return 64'(v - v);
`endif
    endfunction

    task automatic check_stats(input string tag);
        check({tag, " hit_cnt0"},  64'(hit_cnt0),  exp_cnt(m_hit[0]));
        check({tag, " miss_cnt0"}, 64'(miss_cnt0), exp_cnt(m_miss[0]));
        check({tag, " hit_cnt1"},  64'(hit_cnt1),  exp_cnt(m_hit[1]));
        check({tag, " miss_cnt1"}, 64'(miss_cnt1), exp_cnt(m_miss[1]));
    endtask

    task automatic model_reset();
        m_ptr  = 1'b0;
        m_terr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_hit[i]  = 0;
            m_miss[i] = 0;
        end
    endtask

    // One complete lookup, entered and left just after a rising edge.
    // lat > TIMEOUT means the cache never answers.
    task automatic lookup(input string tag, input bit v0, input bit v1,
                          input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                          input int lat, input bit hit);
        bit                g;
        bit                to;
        bit                exp_hit;
        logic [ADDR_W-1:0] ea;

        g       = (v0 && v1) ? m_ptr : v1;
        ea      = g ? a1 : a0;
        m_ptr   = ~g;
        to      = (lat > TIMEOUT);
        exp_hit = !to && hit;

        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
        @(negedge clock_10);
        check({tag, " ready0"}, 64'(req0_ready), 64'(!g));
        check({tag, " ready1"}, 64'(req1_ready), 64'(g));
        check({tag, " idle resp0"}, 64'(resp0_valid), 64'(0));
        check({tag, " idle resp1"}, 64'(resp1_valid), 64'(0));
        check({tag, " idle cache_req"}, 64'(cache_req), 64'(0));

        @(posedge clock_10); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock_10);
        check({tag, " cache_req"}, 64'(cache_req), 64'(1));
        check({tag, " cache_addr"}, 64'(cache_addr), 64'(ea));
        check({tag, " issue busy"}, 64'(busy), 64'(1));

        for (int i = 1; i <= (to ? TIMEOUT : lat); i++) begin
            @(posedge clock_10); #1;
            if (!to && i == lat) begin
                cache_resp_valid = 1'b1;
                cache_resp_hit   = hit;
            end else begin
                cache_resp_valid = 1'b0;
                cache_resp_hit   = 1'($urandom);
            end
            @(negedge clock_10);
            check({tag, " wait cache_req"}, 64'(cache_req), 64'(0));
            check({tag, " wait resp"}, 64'({resp0_valid, resp1_valid}), 64'(0));
            check({tag, " wait busy"}, 64'(busy), 64'(1));
            check({tag, " wait cache_addr"}, 64'(cache_addr), 64'(ea));
        end

        @(posedge clock_10); #1;
        cache_resp_valid = 1'b0;
        cache_resp_hit   = 1'b0;
        if (exp_hit) begin
            if (m_hit[g] < CNT_MAX) m_hit[g]++;
        end else begin
            if (m_miss[g] < CNT_MAX) m_miss[g]++;
        end
        if (to) m_terr = 1'b1;

        @(negedge clock_10);
        check({tag, " resp0_valid"}, 64'(resp0_valid), 64'(!g));
        check({tag, " resp1_valid"}, 64'(resp1_valid), 64'(g));
        check({tag, " resp0_hit"}, 64'(resp0_hit), 64'(!g && exp_hit));
        check({tag, " resp1_hit"}, 64'(resp1_hit), 64'(g && exp_hit));
        check({tag, " done busy"}, 64'(busy), 64'(0));
        check({tag, " timeout_err"}, 64'(timeout_err), 64'(m_terr));
        check_stats(tag);
        @(posedge clock_10); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 64'({req0_ready, req1_ready}), 64'(0));
        check({tag, " resp"}, 64'({resp0_valid, resp0_hit, resp1_valid, resp1_hit}), 64'(0));
        check({tag, " cache_req"}, 64'(cache_req), 64'(0));
        check({tag, " cache_addr"}, 64'(cache_addr), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " timeout_err"}, 64'(timeout_err), 64'(0));
        check_stats(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                r_v0;
        bit                r_v1;
        logic [ADDR_W-1:0] r_a0;
        logic [ADDR_W-1:0] r_a1;

        model_reset();
        repeat (2) @(posedge clock_10);
        @(negedge clock_10);
        check_all_zero("reset");
        @(posedge clock_10); #1;
        reset_10 = 1'b1;
        @(posedge clock_10); #1;

        // Round-robin: both valid, alternating hit/miss, L=1; grants must alternate from requester 0.
        for (int k = 0; k < 8; k++) begin
            lookup("rr", 1'b1, 1'b1, ADDR_W'(32'h100 + k), ADDR_W'(32'h200 + k), 1, (k % 2) == 0);
        end

        lookup("single", 1'b1, 1'b0, ADDR_W'(32'h0000_1234), '0, 3, 1'b1);

        // Response exactly on the last timer cycle is a normal response.
        lookup("expiry", 1'b1, 1'b0, ADDR_W'(32'h0abc), '0, TIMEOUT, 1'b1);

        lookup("timeout", 1'b0, 1'b1, '0, ADDR_W'(32'h0def), TIMEOUT + 1, 1'b1);
        lookup("sticky", 1'b0, 1'b1, '0, ADDR_W'(32'h0456), 1, 1'b1);

        for (int k = 0; k < 9; k++) begin
            lookup("saturate", 1'b1, 1'b0, ADDR_W'(32'h0777), '0, 1, 1'b1);
        end

        for (int k = 0; k < 24; k++) begin
            r_v0 = 1'($urandom);
            r_v1 = 1'($urandom);
            if (!r_v0 && !r_v1) r_v1 = 1'b1;
            r_a0 = ADDR_W'($urandom);
            r_a1 = ADDR_W'($urandom);
            lookup("random", r_v0, r_v1, r_a0, r_a1,
                   int'($urandom_range(1, TIMEOUT + 1)), 1'($urandom));
        end

        // Reset in the middle of WAIT drops the lookup; a late cache response is ignored.
        req0_valid = 1'b1;
        req0_addr  = ADDR_W'(32'h0055);
        @(posedge clock_10); #1;
        req0_valid = 1'b0;
        @(posedge clock_10); #1;
        reset_10 = 1'b0;
        model_reset();
        @(negedge clock_10);
        check_all_zero("midreset");
        @(posedge clock_10); #1;
        reset_10 = 1'b1;
        @(posedge clock_10); #1;
        @(posedge clock_10); #1;
        cache_resp_valid = 1'b1;
        cache_resp_hit   = 1'b1;
        @(negedge clock_10);
        check("late resp busy", 64'(busy), 64'(0));
        @(posedge clock_10); #1;
        cache_resp_valid = 1'b0;
        cache_resp_hit   = 1'b0;
        @(negedge clock_10);
        check("late resp pulse", 64'({resp0_valid, resp1_valid}), 64'(0));
        check_stats("late resp");
        @(posedge clock_10); #1;

        lookup("post reset", 1'b1, 1'b1, ADDR_W'(32'h0011), ADDR_W'(32'h0022), 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
